fpu_add_sched: RTL

Round-robin scheduler sharing one combinational `adder` instance (same `X` parameter) among `N` requesters. Each request carries two IEEE-754 operands and an add/subtract select. The block registers the operands, runs them through the shared adder, and returns the sum with flags on a single tagged response channel with backpressure. It sits between the FPU front-end ports and the adder datapath.

---
 rtl/fpu_pkg.sv | 23 ++
 rtl/adder.sv | 107 ++++++++++
 rtl/fpu_add_sched_arbiter.sv | 35 +++
 rtl/fpu_add_sched.sv | 111 +++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: scheduler state encoding and IEEE-754 field widths
// derived from the operand width.
package fpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_EXEC = 2'd1;
    localparam logic [1:0] STATE_RESP = 2'd2;

    function automatic int expo_bits(input int x);
        return (x == 64) ? 11 : 8;
    endfunction

    function automatic int mant_bits(input int x);
        return (x == 64) ? 52 : 23;
    endfunction

endpackage

// File: rtl/adder.sv
// Combinational IEEE-754 adder (round to nearest even). Subnormals are handled;
// NaN/infinity inputs are passed through, inf - inf yields a quiet NaN.
module adder
    import fpu_pkg::*;
#(
    parameter int X = 32
) (
    input  logic [X-1:0] a,
    input  logic [X-1:0] b,
    output logic [X-1:0] out,
    output logic         overflow,
    output logic         underflow,
    output logic         done
);
    localparam int EB   = expo_bits(X);
    localparam int MB   = mant_bits(X);
    localparam int W    = MB + 5;
    localparam int EMAX = (1 << EB) - 1;

    logic          s_big, s_small, eff_sub, sticky;
    logic [EB-1:0] e_big, e_small;
    logic [MB-1:0] f_big, f_small;
    logic [W-1:0]  m_big, m_small, m_shift, sum;
    logic [MB:0]   mant;
    logic [MB+1:0] mant_r;
    logic          grd, rnd, stk, inexact, round_up;
    int            d, e;

    always_comb begin
        out       = '0;
        overflow  = 1'b0;
        underflow = 1'b0;
        done      = 1'b1;
        mant      = '0;
        mant_r    = '0;
        grd       = 1'b0;
        rnd       = 1'b0;
        stk       = 1'b0;
        inexact   = 1'b0;
        round_up  = 1'b0;

        // Order by magnitude so the result sign is always the larger operand's.
        if (b[X-2:0] > a[X-2:0]) begin
            {s_big, e_big, f_big}       = b;
            {s_small, e_small, f_small} = a;
        end else begin
            {s_big, e_big, f_big}       = a;
            {s_small, e_small, f_small} = b;
        end
        eff_sub = s_big ^ s_small;

        // Layout: carry, hidden, fraction, guard, round, sticky.
        m_big   = {1'b0, e_big != '0, f_big, 3'b000};
        m_small = {1'b0, e_small != '0, f_small, 3'b000};
        e = (e_big == '0) ? 1 : int'(e_big);
        d = e - ((e_small == '0) ? 1 : int'(e_small));

        sticky = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i < d) sticky = sticky | m_small[i];
        end
        m_shift    = (d >= W) ? '0 : (m_small >> d);
        m_shift[0] = m_shift[0] | sticky;
        sum        = eff_sub ? (m_big - m_shift) : (m_big + m_shift);

        if (e_big == EB'(EMAX)) begin
            if (e_small == EB'(EMAX) && eff_sub)
                out = {1'b0, {EB{1'b1}}, 1'b1, {(MB-1){1'b0}}};
            else
                out = {s_big, e_big, f_big};
        end else if (sum == '0) begin
            out = {s_big & s_small, {(X-1){1'b0}}};
        end else begin
            if (sum[W-1]) begin
                sum = {1'b0, sum[W-1:2], sum[1] | sum[0]};
                e   = e + 1;
            end else begin
                for (int i = 0; i < W; i++) begin
                    if (!sum[W-2] && e > 1) begin
                        sum = sum << 1;
                        e   = e - 1;
                    end
                end
            end
            grd      = sum[2];
            rnd      = sum[1];
            stk      = sum[0];
            mant     = sum[W-2:3];
            inexact  = grd | rnd | stk;
            round_up = grd & (rnd | stk | mant[0]);
            mant_r   = {1'b0, mant} + (MB+2)'(round_up);
            if (mant_r[MB+1]) begin
                mant_r = mant_r >> 1;
                e      = e + 1;
            end
            if (e >= EMAX) begin
                overflow = 1'b1;
                out      = {s_big, {EB{1'b1}}, {MB{1'b0}}};
            end else begin
                // A clear hidden bit after normalisation means a subnormal result.
                out       = {s_big, EB'(mant_r[MB] ? e : 0), mant_r[MB-1:0]};
                underflow = !mant_r[MB] && inexact;
            end
        end
    end

endmodule

// File: rtl/fpu_add_sched_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr,
// wrapping from N-1 back to 0.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id
);
    localparam int IDW = $clog2(N);

    logic found;
    int   idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        if (en) begin
            for (int i = 0; i < N; i++) begin
                idx = int'(ptr) + i;
                if (idx >= N) idx = idx - N;
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    gnt_id   = IDW'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/fpu_add_sched.sv
// Round-robin scheduler sharing one combinational adder among N requesters,
// returning tagged results on a single backpressured response channel.
module fpu_add_sched
    import fpu_pkg::*;
#(
    parameter int X   = 32,
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*X-1:0] req_a,
    input  logic [N*X-1:0] req_b,
    input  logic [N-1:0]   req_sub,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [IDW-1:0] rsp_id,
    output logic [X-1:0]   rsp_data,
    output logic           rsp_overflow,
    output logic           rsp_underflow,
    output logic           busy,
    output logic [15:0]    op_count
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and once raised it is held with
    // stable payload until the transfer.

    state_t         state;
    logic [IDW-1:0] rr_ptr, cur_id, gnt_id;
    logic [N-1:0]   gnt;
    logic [X-1:0]   op_a, op_b, sum_out;
    logic           sum_ovf, sum_unf, adder_done_unused;
    logic           rsp_valid_q, rsp_ovf_q, rsp_unf_q;
    logic [IDW-1:0] rsp_id_q;
    logic [X-1:0]   rsp_data_q;
    logic [15:0]    op_cnt_q;

    rr_arbiter #(.N(N)) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .en     (state == ST_IDLE),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    adder #(.X(X)) u_adder (
        .a         (op_a),
        .b         (op_b),
        .out       (sum_out),
        .overflow  (sum_ovf),
        .underflow (sum_unf),
        .done      (adder_done_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            cur_id      <= '0;
            op_a        <= '0;
            op_b        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_unf_q   <= 1'b0;
            op_cnt_q    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        op_a   <= req_a[gnt_id*X +: X];
                        // Subtraction is addition with B's sign bit flipped.
                        op_b   <= req_b[gnt_id*X +: X] ^ {req_sub[gnt_id], {(X-1){1'b0}}};
                        cur_id <= gnt_id;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_data_q  <= sum_out;
                    rsp_ovf_q   <= sum_ovf;
                    rsp_unf_q   <= sum_unf;
                    rsp_id_q    <= cur_id;
                    rsp_valid_q <= 1'b1;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_cnt_q    <= op_cnt_q + 16'd1;
                        rr_ptr      <= (cur_id == IDW'(N-1)) ? '0 : cur_id + 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready     = gnt;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_overflow  = rsp_ovf_q;
    assign rsp_underflow = rsp_unf_q;
    assign busy          = (state != ST_IDLE);
    assign op_count      = op_cnt_q;

endmodule
